// File: rtl/goose_pkg.sv
// Shared constants and types for the per-frame update scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package goose_pkg;

    localparam int N_SLOTS         = 4;
    localparam int DEFAULT_TIMEOUT = 15;

    localparam int SLOT_JUMP   = 0;
    localparam int SLOT_SCROLL = 1;
    localparam int SLOT_OBST   = 2;
    localparam int SLOT_SCORE  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } sched_state_t;

    // ceil(log2(v)) clamped to at least one bit so degenerate parameters still elaborate
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/frame_update_scheduler_slot_timer.sv
// Loadable saturating cycle counter; expired flags the MAX-th counted cycle.
// Latency: count updates one edge after en; expired is combinational from the count.
// Backpressure: none; clear has priority over load, load over enable.
module slot_timer #(
    parameter int MAX = 15,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != W'(MAX))) begin
            count_q <= count_q + W'(1);
        end
    end

    // count_q holds completed cycles, so the cycle in progress is count_q+1
    assign expired = (int'(count_q) + 1) >= MAX;

endmodule

// File: rtl/frame_update_scheduler.sv
// Grants game-state update slots one at a time during vblank with per-slot timeout.
// Latency: vblank_start at edge E -> upd_req[0] in cycle E+1; one cycle per skipped slot; DONE one cycle.
// Backpressure: a slot holds upd_req until its ack or TIMEOUT cycles; frame starts while busy are dropped and flagged.
module frame_update_scheduler #(
    parameter int N_SLOTS = goose_pkg::N_SLOTS,
    parameter int TIMEOUT = goose_pkg::DEFAULT_TIMEOUT,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               vblank_start,
    input  logic               halt,
    input  logic               game_rst,
    input  logic [N_SLOTS-1:0] client_en,
    input  logic [N_SLOTS-1:0] upd_ack,
    output logic [N_SLOTS-1:0] upd_req,
    output logic               busy,
    output logic               frame_done,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic               overrun,
    output logic [N_SLOTS-1:0] timeout_err
);

    import goose_pkg::*;

    localparam int SW = clog2_min1(N_SLOTS);
    localparam int TW = clog2_min1(TIMEOUT + 1);

    sched_state_t state_q;
    sched_state_t state_d;

    logic [SW-1:0]      slot_q;
    logic [N_SLOTS-1:0] en_q;

    logic slot_en;
    logic slot_ack;
    logic expired;
    logic req_active;
    logic advance;
    logic last_slot;
    logic start;
    logic timer_clr;

    assign slot_en    = en_q[slot_q];
    assign slot_ack   = upd_ack[slot_q];
    assign req_active = (state_q == ST_SERVE) && slot_en;
    // disabled slots move on immediately; ack beats a coincident timeout
    assign advance    = (state_q == ST_SERVE) && (!slot_en || slot_ack || expired);
    assign last_slot  = (slot_q == SW'(N_SLOTS - 1));
    assign start      = (state_q == ST_IDLE) && vblank_start && !halt;
    assign timer_clr  = game_rst || !req_active || advance;

    slot_timer #(
        .MAX (TIMEOUT),
        .W   (TW)
    ) u_slot_timer (
        .clk      (clk),
        .rst      (sys_rst),
        .clr      (timer_clr),
        .load     (1'b0),
        .load_val ({TW{1'b0}}),
        .en       (req_active),
        .expired  (expired)
    );

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (game_rst) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start) state_d = ST_SERVE;
                ST_SERVE: if (advance && last_slot) state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // outputs decode registered state only, so upd_ack never reaches upd_req combinationally
    always_comb begin
        upd_req    = '0;
        busy       = (state_q != ST_IDLE);
        frame_done = (state_q == ST_DONE);
        if (req_active) begin
            upd_req[slot_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            slot_q <= '0;
            en_q   <= '0;
        end else if (start && !game_rst) begin
            slot_q <= SW'(SLOT_JUMP);
            en_q   <= client_en;
        end else if (advance && !last_slot && !game_rst) begin
            slot_q <= slot_q + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            frame_cnt   <= '0;
            overrun     <= 1'b0;
            timeout_err <= '0;
        end else if (game_rst) begin
            frame_cnt   <= '0;
            overrun     <= 1'b0;
            timeout_err <= '0;
        end else begin
            if (state_q == ST_DONE) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
            if (vblank_start && (state_q != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            if (req_active && expired && !slot_ack) begin
                timeout_err[slot_q] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Self-checking bench for frame_update_scheduler: table-driven frames with a per-cycle
// scoreboard, plus hand sequences for overrun, halt, resets and counter wrap.
module tb_frame_update_scheduler;

    localparam int NS = 4;
    localparam int TO = 15;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          sys_rst;
    logic          vblank_start;
    logic          halt;
    logic          game_rst;
    logic [NS-1:0] client_en;
    logic [NS-1:0] upd_ack = '0;
    logic [NS-1:0] upd_req;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] frame_cnt;
    logic          overrun;
    logic [NS-1:0] timeout_err;

    int checks   = 0;
    int failures = 0;

    frame_update_scheduler #(
        .N_SLOTS (NS),
        .TIMEOUT (TO),
        .CNT_W   (CW)
    ) dut (
        .clk          (clk),
        .sys_rst      (sys_rst),
        .vblank_start (vblank_start),
        .halt         (halt),
        .game_rst     (game_rst),
        .client_en    (client_en),
        .upd_ack      (upd_ack),
        .upd_req      (upd_req),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_cnt    (frame_cnt),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // Client model: acks the granted slot in its (ack_dly+1)-th req cycle; ack_dly<0 never acks.
    // noise drives ack on every non-granted slot.
    int            ack_dly  = -1;
    logic [NS-1:0] noise    = '0;
    logic [NS-1:0] last_req = '0;
    int            age      = 0;

    always @(negedge clk) begin
        if (upd_req != '0 && upd_req == last_req) age = age + 1;
        else age = 0;
        last_req = upd_req;
        upd_ack  = ((ack_dly >= 0 && age == ack_dly) ? upd_req : '0) | (noise & ~upd_req);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [NS-1:0] req;
        logic          done;
    } exp_t;
    exp_t sb[$];

    task automatic push_frame(input logic [NS-1:0] en, input int dly);
        for (int s = 0; s < NS; s++) begin
            if (en[s]) begin
                int len;
                len = (dly < 0 || dly + 1 > TO) ? TO : dly + 1;
                for (int k = 0; k < len; k++) sb.push_back('{req: NS'(1 << s), done: 1'b0});
            end else begin
                sb.push_back('{req: '0, done: 1'b0});
            end
        end
        sb.push_back('{req: '0, done: 1'b1});
    endtask

    // Called at the negedge where vblank_start was raised (cycle 0); returns frame_done cycle.
    task automatic drain(output int done_c);
        int   c;
        exp_t e;
        c      = 0;
        done_c = -1;
        while (sb.size() > 0) begin
            @(negedge clk);
            c++;
            if (c == 1) vblank_start = 1'b0;
            e = sb.pop_front();
            chk("sb_upd_req", 32'(upd_req), 32'(e.req));
            chk("sb_frame_done", 32'(frame_done), 32'(e.done));
            chk("sb_busy", 32'(busy), 32'd1);
            if (frame_done) done_c = c;
        end
    endtask

    typedef struct {
        logic [NS-1:0] en;
        int            dly;
        logic [NS-1:0] noise;
        int            exp_done;
        logic [NS-1:0] exp_terr;
    } vec_t;
    vec_t tbl[7];

    initial begin
        int done_c;
        int pulses;
        logic [NS-1:0] req_or;
        logic busy_or;
        logic seen;

        tbl[0] = '{en: 4'b1111, dly:  0, noise: 4'b0000, exp_done:  5, exp_terr: 4'b0000};
        tbl[1] = '{en: 4'b0101, dly:  1, noise: 4'b0000, exp_done:  7, exp_terr: 4'b0000};
        tbl[2] = '{en: 4'b0010, dly: -1, noise: 4'b0000, exp_done: 19, exp_terr: 4'b0010};
        tbl[3] = '{en: 4'b1000, dly: 14, noise: 4'b0000, exp_done: 19, exp_terr: 4'b0010};
        tbl[4] = '{en: 4'b0000, dly:  0, noise: 4'b0000, exp_done:  5, exp_terr: 4'b0010};
        tbl[5] = '{en: 4'b1111, dly:  2, noise: 4'b1111, exp_done: 13, exp_terr: 4'b0010};
        tbl[6] = '{en: 4'b0110, dly: 15, noise: 4'b0000, exp_done: 33, exp_terr: 4'b0110};

        sys_rst = 1'b1; vblank_start = 1'b0; halt = 1'b0; game_rst = 1'b0; client_en = '0;
        repeat (2) @(negedge clk);
        chk("rst_upd_req", 32'(upd_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        sys_rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        for (int r = 0; r < 7; r++) begin
            client_en = tbl[r].en; ack_dly = tbl[r].dly; noise = tbl[r].noise;
            vblank_start = 1'b1;
            push_frame(tbl[r].en, tbl[r].dly);
            drain(done_c);
            chk("tbl_done_cycle", 32'(done_c), 32'(tbl[r].exp_done));
            @(negedge clk);
            chk("tbl_frame_cnt", 32'(frame_cnt), 32'(r + 1));
            chk("tbl_timeout_err", 32'(timeout_err), 32'(tbl[r].exp_terr));
            chk("tbl_busy_after", 32'(busy), 32'd0);
        end
        noise = '0;

        // second vblank_start mid-frame: flagged, otherwise ignored
        client_en = 4'b1111; ack_dly = 1; vblank_start = 1'b1; pulses = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            vblank_start = (c == 3);
            if (frame_done) pulses++;
        end
        chk("ovr_pulses", 32'(pulses), 32'd1);
        chk("ovr_overrun", 32'(overrun), 32'd1);
        chk("ovr_frame_cnt", 32'(frame_cnt), 32'd8);

        // halt at vblank_start blocks the frame
        halt = 1'b1; vblank_start = 1'b1; req_or = '0; busy_or = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            vblank_start = 1'b0;
            req_or  = req_or | upd_req;
            busy_or = busy_or | busy;
        end
        chk("halt_req", 32'(req_or), 32'd0);
        chk("halt_busy", 32'(busy_or), 32'd0);
        chk("halt_frame_cnt", 32'(frame_cnt), 32'd8);

        // halt rising mid-frame lets the frame finish
        halt = 1'b0; ack_dly = 0; vblank_start = 1'b1; pulses = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            vblank_start = 1'b0;
            if (c == 2) halt = 1'b1;
            if (frame_done) pulses++;
        end
        chk("halt_mid_pulses", 32'(pulses), 32'd1);
        chk("halt_mid_frame_cnt", 32'(frame_cnt), 32'd9);
        halt = 1'b0;

        // asynchronous sys_rst between edges clears outputs immediately
        client_en = 4'b0010; ack_dly = -1; vblank_start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            vblank_start = 1'b0;
        end
        chk("arst_pre_req", 32'(upd_req), 32'b0010);
        #2 sys_rst = 1'b1;
        #1;
        chk("arst_upd_req", 32'(upd_req), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("arst_overrun", 32'(overrun), 32'd0);
        chk("arst_timeout_err", 32'(timeout_err), 32'd0);
        @(negedge clk);
        sys_rst = 1'b0;

        client_en = 4'b0000; vblank_start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            vblank_start = 1'b0;
        end
        chk("post_arst_frame_cnt", 32'(frame_cnt), 32'd1);

        // game_rst mid-SERVE with sticky flags set and a coincident vblank_start
        client_en = 4'b0110; ack_dly = -1; vblank_start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            vblank_start = (c == 2);
        end
        chk("grst_pre_terr", 32'(timeout_err), 32'b0010);
        chk("grst_pre_overrun", 32'(overrun), 32'd1);
        chk("grst_pre_req", 32'(upd_req), 32'b0100);
        game_rst = 1'b1; vblank_start = 1'b1;
        @(negedge clk);
        game_rst = 1'b0; vblank_start = 1'b0;
        chk("grst_upd_req", 32'(upd_req), 32'd0);
        chk("grst_busy", 32'(busy), 32'd0);
        chk("grst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("grst_overrun", 32'(overrun), 32'd0);
        chk("grst_timeout_err", 32'(timeout_err), 32'd0);
        @(negedge clk);
        chk("grst_vblank_ignored", 32'(busy), 32'd0);

        // 256 frames wrap the counter
        client_en = 4'b0000;
        for (int f = 1; f <= 256; f++) begin
            vblank_start = 1'b1;
            seen = 1'b0;
            for (int c = 1; c <= 20 && !seen; c++) begin
                @(negedge clk);
                vblank_start = 1'b0;
                if (frame_done) seen = 1'b1;
            end
            chk("wrap_done_seen", 32'(seen), 32'd1);
            @(negedge clk);
            if (f == 255) chk("wrap_cnt_255", 32'(frame_cnt), 32'd255);
        end
        chk("wrap_cnt_0", 32'(frame_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_update_scheduler.md
Name: frame_update_scheduler

Overview:
- Sequences the once-per-frame game-state updates (jump physics, scroll, obstacle/controller step, score) during vertical blank, so no update collides with active-video rendering.
- Grants one client at a time, in fixed slot order, over a req/ack handshake with per-slot timeout.
- Sits between hvsync_generator (frame-start strobe) and the update-side logic of jumping, scroll and game_controller; the top level fans out upd_req and collects upd_ack.

Parameters:
- N_SLOTS, 4, number of update clients; slot 0 is served first.
- TIMEOUT, 15, max cycles upd_req[i] stays high without ack before the slot is abandoned (range 1..255).
- CNT_W, 8, width of frame_cnt.

Ports:
- clk  input  1  system clock (pixel clock)
- sys_rst  input  1  asynchronous, active-high reset
- vblank_start  input  1  one-cycle pulse at first vblank pixel (vpos==480, hpos==0)
- halt  input  1  game_halt level; frames are not started while high
- game_rst  input  1  synchronous soft reset from game controller
- client_en  input  N_SLOTS  per-slot enable mask, latched at frame start
- upd_ack  input  N_SLOTS  client completion, sampled only for the granted slot
- upd_req  output  N_SLOTS  one-hot (or zero) update request, level until ack/timeout
- busy  output  1  high from frame start until DONE inclusive
- frame_done  output  1  one-cycle pulse when all slots served
- frame_cnt  output  CNT_W  completed-frame count, wraps 2^CNT_W-1 -> 0
- overrun  output  1  sticky: vblank_start arrived while busy
- timeout_err  output  N_SLOTS  sticky per slot: slot timed out

Behaviour:
- Reset (sys_rst, async): state IDLE, slot=0, upd_req=0, busy=0, frame_done=0, frame_cnt=0, overrun=0, timeout_err=0, en_q=0, timer=0.
- States: IDLE, SERVE, DONE.
- IDLE: on vblank_start && !halt -> latch en_q<=client_en, slot<=0, timer<=0, -> SERVE. vblank_start with halt high: ignored, no count.
- SERVE, en_q[slot]==0: slot skipped, costs exactly one cycle, upd_req=0.
- SERVE, en_q[slot]==1: upd_req = one-hot(slot), decoded from registered state (no input-to-output path).
  - Handshake completes at an edge where upd_req[slot] && upd_ack[slot]; minimum one cycle of req.
  - Timer counts cycles with req high; after TIMEOUT cycles without ack, timeout_err[slot]<=1 and slot advances.
  - Ack and timeout at the same edge: ack wins, no error.
- After slot N_SLOTS-1 completes, skips or times out -> DONE.
- DONE: one cycle; frame_done=1, busy=1; frame_cnt increments at the exiting edge; -> IDLE.
- upd_ack bits for non-granted slots are ignored.
- Latency: vblank_start sampled at edge E -> upd_req[0] high in cycle E+1. With all slots enabled and immediate ack, each slot takes 1 cycle, DONE is in cycle E+5, and frame_cnt is updated in cycle E+6.
- halt rising mid-frame: the current frame completes normally; only new frame starts are blocked.
- vblank_start while busy (SERVE/DONE): overrun<=1, pulse otherwise ignored. vblank_start in the same cycle as the IDLE return is accepted.
- game_rst (sync, highest priority after sys_rst): in one cycle returns to IDLE, clears upd_req, busy, frame_cnt, overrun, timeout_err and timer; any vblank_start that cycle is ignored.
- client_en changes mid-frame have no effect until the next frame start.
- Timer width is ceil(log2(TIMEOUT+1)) bits; it saturates, never wraps.

Decomposition:
- Shared package goose_pkg:
  - Slot constants SLOT_JUMP=0, SLOT_SCROLL=1, SLOT_OBST=2, SLOT_SCORE=3.
  - N_SLOTS.
  - State encoding typedef (IDLE/SERVE/DONE).
  - Default TIMEOUT.
- Sub-module slot_timer: loadable saturating counter with clear/enable inputs and an expired output. Everything else stays in one module.

Test Plan:
- All en=4'b1111, upd_ack tied to upd_req, vblank_start at cycle 0 -> upd_req = 0001, 0010, 0100, 1000 in cycles 1-4; frame_done in cycle 5; frame_cnt=1 in cycle 6; no errors.
- en=4'b0101, ack 2 cycles after req -> req[0] high cycles 1-2, cycle 3 skip, req[2] high cycles 4-5, cycle 6 skip, frame_done in cycle 7.
- en=4'b0010, ack never asserted, TIMEOUT=15 -> req[1] high exactly 15 cycles; timeout_err=4'b0010 (sticky across following frames); frame_done still pulses.
- Second vblank_start during SERVE -> overrun=1, one frame_done only, frame_cnt +1. halt high at vblank_start -> no req, frame_cnt unchanged.
- 256 completed frames -> frame_cnt wraps 255->0. game_rst asserted mid-SERVE -> next cycle upd_req=0, busy=0, frame_cnt=0, all sticky flags clear.
- sys_rst asserted asynchronously mid-SERVE (between edges) -> all outputs zero immediately, without waiting for a clock edge.
